pwm_peripheral: RTL

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 78 +++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: shared prescaler, 8-bit PWM counter and duty shadow,
// with per-channel output-enable and PWM/static-high mode select.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_sh;
  logic        tick;
  logic        wrap;
  logic        lvl;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_nxt;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Level is decoded from the registered counter/shadow so every channel
  // switches on the same edge with no phase offset between them.
  always_comb begin
    tick    = (presc == PRESC_MAX);
    wrap    = tick && (pwm_cnt == 8'hFF);
    lvl     = (duty_sh == 8'hFF) ? 1'b1 : (pwm_cnt < duty_sh);
    out_nxt = en_out & (~en_pwm | {16{lvl}});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + 16'd1;
    end
  end

  // Duty is only sampled at the period boundary so mid-period writes
  // never distort the waveform currently being generated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) duty_sh <= pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_7_0  <= '0;
      out_15_8 <= '0;
    end else begin
      out_7_0  <= out_nxt[7:0];
      out_15_8 <= out_nxt[15:8];
    end
  end

endmodule
